mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one word-wide memory port between the instruction-fetch requester and the load/store requester of the RV32I core.
- Both requesters use the request / we_re / mask / valid handshake that fetch already uses. The arbiter grants one transaction at a time and drives the registered memory command.
- Routes the response back to the granted requester and produces a stall signal for the PC.
- A watchdog aborts any transaction the memory never answers.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; mask width is DATA_W/8.
- TIMEOUT, 255, wait cycles before a transaction is aborted; legal range 1..2^16-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_request  in  1  fetch wants a read.
- if_address  in  ADDR_W  fetch address.
- if_valid  out  1  one-cycle pulse: fetch data returned.
- if_rdata  out  DATA_W  fetch data; valid only while if_valid is high.
- d_request  in  1  load/store wants an access.
- d_we_re  in  1  1 = write, 0 = read.
- d_mask  in  DATA_W/8  byte enables.
- d_address  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_valid  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_W  load data; valid only while d_valid is high.
- mem_request  out  1  command to memory.
- mem_we_re  out  1  to memory.
- mem_mask  out  DATA_W/8  to memory.
- mem_address  out  ADDR_W  to memory.
- mem_wdata  out  DATA_W  to memory.
- mem_valid  in  1  memory completion.
- mem_rdata  in  DATA_W  memory read data.
- stall  out  1  hold the PC.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst low, async):
  - state=IDLE; last_grant=FETCH; counter=0.
  - All mem_* outputs, if_valid, d_valid, if_rdata, d_rdata and bus_err are 0.
- States: IDLE, IF_WAIT, D_WAIT.
- IDLE, grant decision:
  - Only one requester asserted: grant it.
  - Both asserted: grant the one that is not last_grant, so data wins first after reset.
  - On the grant edge, register the command into mem_*, set mem_request=1, set last_grant, clear counter, and go to IF_WAIT or D_WAIT.
  - A fetch grant forces mem_we_re=0 and mem_mask=all ones.
- WAIT states:
  - mem_* stay constant and mem_request stays high.
  - mem_valid is sampled only while mem_request=1.
  - On mem_valid: on the next edge clear mem_request, register mem_rdata into the granted x_rdata, pulse the granted x_valid for one cycle, and return to IDLE.
- Latency:
  - Request at cycle N gives mem_request at N+1.
  - mem_valid at cycle M (M ≥ N+1) gives x_valid at M+1.
  - A new grant is possible at the edge ending cycle M+1, so the minimum spacing between back-to-back transactions is 2 cycles.
- Timeout:
  - The counter increments each WAIT cycle without mem_valid.
  - On reaching TIMEOUT: clear mem_request, set bus_err, pulse the granted x_valid with x_rdata=0, and return to IDLE.
  - mem_valid arriving in the same cycle as the timeout takes priority: normal completion, no error.
  - bus_err clears only on reset.
- Dropped request: if the requester drops its request mid-transaction, the transaction still completes and x_valid still pulses; the requester ignores it.
- Stray completions: mem_valid in IDLE is ignored.
- Stall:
  - stall = (if_request & ~if_valid) | (d_request & ~d_valid), combinational.
  - Covers a load/store that keeps the PC held until d_valid.
- Requester rule: each requester holds request and its command stable until its valid. The arbiter samples commands only at grant.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE/IF_WAIT/D_WAIT), grant encoding (FETCH=0, DATA=1), default TIMEOUT constant.
- Sub-module arb_watchdog: clear/enable inputs, expired output, width from $clog2(TIMEOUT+1).

Test Plan:
- Reset then if_request=1, if_address=0x0000_0010, memory answers mem_valid at the 3rd WAIT cycle with 0x0010_0093 -> mem_request high for 3 cycles with mem_address=0x10, mem_we_re=0, mask=0xF; if_valid pulses once with if_rdata=0x0010_0093; stall falls the same cycle.
- if_request and d_request both held (load to 0x100) with memory answering in 1 cycle -> grant order DATA, FETCH, DATA, FETCH; each x_valid pulse is 2 cycles apart.
- Store: d_we_re=1, d_mask=0x3, d_address=0x200, d_wdata=0xDEAD_BEEF -> mem_* carry exactly these values; d_valid pulses after mem_valid; if_valid stays 0.
- TIMEOUT=4, memory never answers -> mem_request drops after 4 WAIT cycles; bus_err=1 and stays 1; x_valid pulses with rdata=0; a next request is still served.
- rst pulled low mid D_WAIT -> mem_request and all outputs go to 0 immediately, before the next clock edge. After release, a mem_valid arriving in IDLE produces no x_valid pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_t;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/arb_watchdog.sv
// Counts wait cycles without a memory answer and flags the cycle in which
// the count would reach TIMEOUT.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // Expiry is seen one cycle early so the abort lands on the TIMEOUT-th edge.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with
// alternating priority, per-requester response routing and a watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_request,
  input  logic [ADDR_W-1:0]   if_address,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_request,
  input  logic                d_we_re,
  input  logic [DATA_W/8-1:0] d_mask,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_request,
  output logic                mem_we_re,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                bus_err
);

  arb_state_t state, state_next;
  grant_t     last_grant;
  logic       grant_if, grant_d, done, abort;
  logic       wd_enable, wd_expired;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_if | grant_d),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // On contention, grant the requester that did not win last time.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    wd_enable  = 1'b0;
    case (state)
      IDLE: begin
        if (d_request && (!if_request || last_grant == FETCH)) begin
          grant_d    = 1'b1;
          state_next = D_WAIT;
        end else if (if_request) begin
          grant_if   = 1'b1;
          state_next = IF_WAIT;
        end
      end
      IF_WAIT, D_WAIT: begin
        wd_enable = mem_request && !mem_valid;
        if (mem_request && mem_valid) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (wd_expired) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant  <= FETCH;
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_mask    <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      if_valid    <= 1'b0;
      if_rdata    <= '0;
      d_valid     <= 1'b0;
      d_rdata     <= '0;
      bus_err     <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (grant_d) begin
        last_grant  <= DATA;
        mem_request <= 1'b1;
        mem_we_re   <= d_we_re;
        mem_mask    <= d_mask;
        mem_address <= d_address;
        mem_wdata   <= d_wdata;
      end
      if (grant_if) begin
        last_grant  <= FETCH;
        mem_request <= 1'b1;
        mem_we_re   <= 1'b0;
        mem_mask    <= '1;
        mem_address <= if_address;
      end
      // An aborted transaction still answers its requester, with zero data.
      if (done || abort) begin
        mem_request <= 1'b0;
        if (state == IF_WAIT) begin
          if_valid <= 1'b1;
          if_rdata <= done ? mem_rdata : '0;
        end else begin
          d_valid <= 1'b1;
          d_rdata <= done ? mem_rdata : '0;
        end
      end
      if (abort) bus_err <= 1'b1;
    end
  end

  assign stall = (if_request & ~if_valid) | (d_request & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: responder model plus a response scoreboard.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_request, if_valid;
  logic [31:0] if_address, if_rdata;
  logic        d_request, d_we_re, d_valid;
  logic [3:0]  d_mask;
  logic [31:0] d_address, d_wdata, d_rdata;
  logic        mem_request, mem_we_re, mem_valid;
  logic [3:0]  mem_mask;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        stall, bus_err;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   resp_delay;
  int   wait_cnt = 0;
  logic force_valid;
  logic resp_hit = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_request(if_request), .if_address(if_address), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_request(d_request), .d_we_re(d_we_re), .d_mask(d_mask), .d_address(d_address),
    .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .stall(stall), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    if (a == 32'h10) return 32'h0010_0093;
    return (a ^ 32'h5A5A_0000) + 32'h1;
  endfunction

  assign mem_rdata = mem_fn(mem_address);
  assign mem_valid = force_valid | resp_hit;

  // Memory answers on the resp_delay-th wait cycle; resp_delay of 0 means never.
  always @(posedge clk) begin
    #1;
    if (mem_request) begin
      wait_cnt = wait_cnt + 1;
      resp_hit = (resp_delay != 0) && (wait_cnt == resp_delay);
    end else begin
      wait_cnt = 0;
      resp_hit = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && (if_valid || d_valid)) begin
      check("resp_one_port", {31'd0, if_valid & d_valid}, 32'd0);
      check("resp_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("resp_port", {31'd0, d_valid}, {31'd0, e.is_data});
        check("resp_rdata", d_valid ? d_rdata : if_rdata, e.rdata);
      end
    end
  end

  initial begin
    int req_cycles, nvalid, cyc, last_cyc;
    logic got, seen, if_seen;
    rst = 1'b0; if_request = 1'b0; if_address = '0; d_request = 1'b0; d_we_re = 1'b0;
    d_mask = '0; d_address = '0; d_wdata = '0; resp_delay = 0; force_valid = 1'b0;
    tick(); tick();
    check("rst_mem_request", mem_request, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_mask", mem_mask, 0);
    check("rst_valids", {if_valid, d_valid}, 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    check("rst_bus_err", bus_err, 0);
    rst = 1'b1;
    tick();

    // single fetch answered on the third wait cycle
    resp_delay = 3; if_request = 1'b1; if_address = 32'h10;
    sb.push_back('{1'b0, 32'h0010_0093});
    #1;
    check("t1_stall_pending", stall, 1);
    req_cycles = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (mem_request) begin
        if (req_cycles == 0) begin
          check("t1_mem_address", mem_address, 32'h10);
          check("t1_mem_we_re", mem_we_re, 0);
          check("t1_mem_mask", mem_mask, 4'hF);
        end
        req_cycles++;
      end
      if (if_valid) begin
        got = 1'b1;
        check("t1_stall_fall", stall, 0);
      end
    end
    check("t1_got_valid", got, 1);
    check("t1_req_cycles", req_cycles, 3);
    if_request = 1'b0;
    tick();
    check("t1_single_pulse", if_valid, 0);

    // both requesters held: alternating grants starting with data
    resp_delay = 1; if_address = 32'h40; d_address = 32'h100; d_mask = 4'hF; d_we_re = 1'b0;
    sb.push_back('{1'b1, mem_fn(32'h100)});
    sb.push_back('{1'b0, mem_fn(32'h40)});
    sb.push_back('{1'b1, mem_fn(32'h100)});
    sb.push_back('{1'b0, mem_fn(32'h40)});
    if_request = 1'b1; d_request = 1'b1;
    nvalid = 0; cyc = 0; last_cyc = 0;
    for (int i = 0; i < 40 && nvalid < 4; i++) begin
      tick();
      cyc++;
      if (if_valid || d_valid) begin
        if (nvalid > 0) check("t2_spacing", cyc - last_cyc, 2);
        last_cyc = cyc;
        nvalid++;
      end
    end
    check("t2_count", nvalid, 4);
    if_request = 1'b0; d_request = 1'b0;
    tick();

    // store command passes through untouched
    resp_delay = 2; d_we_re = 1'b1; d_mask = 4'h3; d_address = 32'h200; d_wdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b1, mem_fn(32'h200)});
    d_request = 1'b1;
    got = 1'b0; seen = 1'b0; if_seen = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (mem_request && !seen) begin
        seen = 1'b1;
        check("t3_mem_we_re", mem_we_re, 1);
        check("t3_mem_mask", mem_mask, 4'h3);
        check("t3_mem_address", mem_address, 32'h200);
        check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      end
      if (if_valid) if_seen = 1'b1;
      if (d_valid) got = 1'b1;
    end
    check("t3_cmd_seen", seen, 1);
    check("t3_got_valid", got, 1);
    check("t3_no_if_valid", if_seen, 0);
    d_request = 1'b0; d_we_re = 1'b0;
    tick();

    // memory never answers: abort after four wait cycles
    resp_delay = 0;
    check("t4_bus_err_before", bus_err, 0);
    if_request = 1'b1; if_address = 32'h80;
    sb.push_back('{1'b0, 32'h0});
    req_cycles = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (mem_request) req_cycles++;
      if (if_valid) begin
        got = 1'b1;
        check("t4_bus_err_set", bus_err, 1);
      end
    end
    check("t4_got_valid", got, 1);
    check("t4_req_cycles", req_cycles, 4);
    if_request = 1'b0;
    tick();
    check("t4_bus_err_sticky", bus_err, 1);
    resp_delay = 1; d_address = 32'h300; d_mask = 4'hF;
    sb.push_back('{1'b1, mem_fn(32'h300)});
    d_request = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (d_valid) got = 1'b1;
    end
    check("t4_next_served", got, 1);
    check("t4_bus_err_kept", bus_err, 1);
    d_request = 1'b0;
    tick();

    // asynchronous reset in the middle of a data wait
    resp_delay = 0; d_address = 32'h400; d_request = 1'b1;
    tick(); tick();
    check("t5_in_wait", mem_request, 1);
    check("t5_wait_address", mem_address, 32'h400);
    #2;
    rst = 1'b0; d_request = 1'b0;
    #1;
    check("t5_async_request", mem_request, 0);
    check("t5_async_address", mem_address, 0);
    check("t5_async_mask", mem_mask, 0);
    check("t5_async_bus_err", bus_err, 0);
    check("t5_async_stall", stall, 0);
    tick();
    rst = 1'b1;
    tick();
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    check("t5_stray_ignored", {if_valid, d_valid}, 0);
    tick();
    check("t5_stray_idle", {if_valid, d_valid, mem_request}, 0);

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
